// File: rtl/oram_block_adapter_pkg.sv
// Shared definitions for the ORAM block adapter: backend command encodings,
// default beat geometry and FSM state encoding.
package oram_block_adapter_pkg;

    typedef enum logic [1:0] {
        CmdUpdate  = 2'd0,
        CmdAppend  = 2'd1,
        CmdRead    = 2'd2,
        CmdReadRmv = 2'd3
    } becmd_e;

    localparam int unsigned DefOramu      = 32;
    localparam int unsigned DefOramb      = 512;
    localparam int unsigned DefFedWidth   = 64;
    localparam int unsigned DefBecmdWidth = 2;
    localparam int unsigned Beats         = DefOramb / DefFedWidth;
    localparam int unsigned BeatCntWidth  = (Beats > 1) ? $clog2(Beats) : 1;

    typedef enum logic [2:0] {
        StIdle,
        StCmd,
        StWdata,
        StRdata,
        StResp
    } state_e;

    // Update/Append carry a write block; Read/ReadRmv return one.
    function automatic logic cmd_is_write(input logic [1:0] cmd);
        return (cmd == CmdUpdate) || (cmd == CmdAppend);
    endfunction

endpackage

// File: rtl/oram_block_shifter.sv
// Block-wide PISO/SIPO register: parallel load, beat-indexed read-out for write
// data and beat-indexed write-in for read data, sharing one beat counter.
module oram_block_shifter #(
    parameter int unsigned ORAMB    = 512,
    parameter int unsigned FEDWidth = 64,
    localparam int unsigned NBeats  = ORAMB / FEDWidth,
    localparam int unsigned CntW    = (NBeats > 1) ? $clog2(NBeats) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load,
    input  logic [ORAMB-1:0]    load_data,
    input  logic                advance,
    input  logic                beat_wr,
    input  logic [FEDWidth-1:0] beat_wdata,
    input  logic                cnt_clr,
    output logic [ORAMB-1:0]    block,
    output logic [FEDWidth-1:0] beat_out,
    output logic                cnt_last
);

    logic [ORAMB-1:0] block_q;
    logic [CntW-1:0]  cnt_q;

    assign cnt_last = (cnt_q == CntW'(NBeats - 1));
    assign block    = block_q;
    assign beat_out = block_q[cnt_q*FEDWidth +: FEDWidth];

    // Counter saturates at the last beat; the FSM clears it on leaving a burst.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (cnt_clr) begin
            cnt_q <= '0;
        end else if ((advance || beat_wr) && !cnt_last) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            block_q <= '0;
        end else if (load) begin
            block_q <= load_data;
        end else if (beat_wr) begin
            block_q[cnt_q*FEDWidth +: FEDWidth] <= beat_wdata;
        end
    end

endmodule

// File: rtl/oram_block_adapter.sv
// Whole-block request front end for the ORAM controller: issues one command,
// then streams the block out as write beats or gathers read beats into a response.
module oram_block_adapter
    import oram_block_adapter_pkg::*;
#(
    parameter int unsigned ORAMU      = DefOramu,
    parameter int unsigned ORAMB      = DefOramb,
    parameter int unsigned FEDWidth   = DefFedWidth,
    parameter int unsigned BECMDWidth = DefBecmdWidth
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [BECMDWidth-1:0] req_cmd,
    input  logic [ORAMU-1:0]      req_addr,
    input  logic [ORAMB-1:0]      req_data,
    input  logic                  req_valid,
    output logic                  req_ready,
    output logic [ORAMB-1:0]      resp_data,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [BECMDWidth-1:0] cmd,
    output logic [ORAMU-1:0]      paddr,
    output logic                  cmd_valid,
    input  logic                  cmd_ready,
    output logic [FEDWidth-1:0]   data_in,
    output logic                  data_in_valid,
    input  logic                  data_in_ready,
    input  logic [FEDWidth-1:0]   data_out,
    input  logic                  data_out_valid,
    output logic                  data_out_ready
);

    if (ORAMB % FEDWidth != 0) begin : g_bad_geometry
        $error("ORAMB must be a multiple of FEDWidth");
    end

    state_e                state_q, state_d;
    logic [BECMDWidth-1:0] cmd_q;
    logic [ORAMU-1:0]      paddr_q;
    logic                  is_write;
    logic                  load, advance, beat_wr, cnt_clr, cnt_last;
    logic [ORAMB-1:0]      load_data;

    assign is_write  = cmd_is_write(2'(cmd_q));
    // Reads start from a cleared block so a response only ever holds fresh beats.
    assign load_data = cmd_is_write(2'(req_cmd)) ? req_data : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cmd_q   <= '0;
            paddr_q <= '0;
        end else begin
            state_q <= state_d;
            if (load) begin
                cmd_q   <= req_cmd;
                paddr_q <= req_addr;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (req_valid) state_d = StCmd;
            StCmd:   if (cmd_ready) state_d = is_write ? StWdata : StRdata;
            StWdata: if (data_in_ready && cnt_last) state_d = StIdle;
            StRdata: if (data_out_valid && cnt_last) state_d = StResp;
            StResp:  if (resp_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        req_ready      = (state_q == StIdle);
        cmd_valid      = (state_q == StCmd);
        data_in_valid  = (state_q == StWdata);
        data_out_ready = (state_q == StRdata);
        resp_valid     = (state_q == StResp);
        load           = req_ready && req_valid;
        advance        = data_in_valid && data_in_ready;
        beat_wr        = data_out_ready && data_out_valid;
        cnt_clr        = (cmd_valid && cmd_ready) || (advance && cnt_last) ||
                         (beat_wr && cnt_last);
    end

    assign cmd   = cmd_q;
    assign paddr = paddr_q;

    oram_block_shifter #(
        .ORAMB   (ORAMB),
        .FEDWidth(FEDWidth)
    ) u_shifter (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .load_data (load_data),
        .advance   (advance),
        .beat_wr   (beat_wr),
        .beat_wdata(data_out),
        .cnt_clr   (cnt_clr),
        .block     (resp_data),
        .beat_out  (data_in),
        .cnt_last  (cnt_last)
    );

endmodule

// File: tb/tb_oram_block_adapter.sv
// Directed bench for oram_block_adapter: write/read bursts, backpressure,
// mid-burst reset and stray read beats.
module tb_oram_block_adapter;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [1:0]   req_cmd;
    logic [31:0]  req_addr;
    logic [511:0] req_data;
    logic         req_valid;
    logic         req_ready;
    logic [511:0] resp_data;
    logic         resp_valid;
    logic         resp_ready;
    logic [1:0]   cmd;
    logic [31:0]  paddr;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [63:0]  data_in;
    logic         data_in_valid;
    logic         data_in_ready;
    logic [63:0]  data_out;
    logic         data_out_valid;
    logic         data_out_ready;

    int total = 0;
    int bad   = 0;

    oram_block_adapter dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_cmd       (req_cmd),
        .req_addr      (req_addr),
        .req_data      (req_data),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .resp_data     (resp_data),
        .resp_valid    (resp_valid),
        .resp_ready    (resp_ready),
        .cmd           (cmd),
        .paddr         (paddr),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .data_in       (data_in),
        .data_in_valid (data_in_valid),
        .data_in_ready (data_in_ready),
        .data_out      (data_out),
        .data_out_valid(data_out_valid),
        .data_out_ready(data_out_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [1:0] c, input logic [31:0] a, input logic [511:0] d);
        chk("req_ready_idle", req_ready, 1'b1);
        req_cmd   = c;
        req_addr  = a;
        req_data  = d;
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        req_data  = '0;
    endtask

    logic [511:0] blk;
    logic [511:0] snap;
    int           idx;

    initial begin
        rst_n          = 1'b0;
        req_cmd        = '0;
        req_addr       = '0;
        req_data       = '0;
        req_valid      = 1'b0;
        resp_ready     = 1'b0;
        cmd_ready      = 1'b1;
        data_in_ready  = 1'b1;
        data_out       = '0;
        data_out_valid = 1'b0;
        #2;
        chk("rst_cmd_valid", cmd_valid, 1'b0);
        chk("rst_din_valid", data_in_valid, 1'b0);
        chk("rst_dout_ready", data_out_ready, 1'b0);
        chk("rst_resp_valid", resp_valid, 1'b0);
        chk("rst_resp_data", resp_data, '0);
        chk("rst_data_in", data_in, '0);
        chk("rst_cmd", cmd, '0);
        chk("rst_paddr", paddr, '0);
        step();
        step();
        rst_n = 1'b1;
        step();
        chk("rst_req_ready", req_ready, 1'b1);

        // 1: append, beats 0..7, all readies high
        for (int i = 0; i < 8; i++) blk[i*64 +: 64] = 64'(i);
        issue(2'd1, 32'h1234, blk);
        chk("t1_cmd_valid", cmd_valid, 1'b1);
        chk("t1_cmd", cmd, 2'd1);
        chk("t1_paddr", paddr, 32'h1234);
        chk("t1_req_ready_busy", req_ready, 1'b0);
        step();
        for (int i = 0; i < 8; i++) begin
            chk("t1_din_valid", data_in_valid, 1'b1);
            chk("t1_din", data_in, 64'(i));
            step();
        end
        chk("t1_din_valid_end", data_in_valid, 1'b0);
        chk("t1_req_ready_end", req_ready, 1'b1);

        // 2: read with gaps between beats
        issue(2'd2, 32'hABCD, '1);
        chk("t2_cmd", cmd, 2'd2);
        chk("t2_paddr", paddr, 32'hABCD);
        step();
        for (int i = 0; i < 8; i++) begin
            blk[i*64 +: 64] = 64'(8'h11 * (i + 1));
            chk("t2_dout_ready", data_out_ready, 1'b1);
            data_out       = blk[i*64 +: 64];
            data_out_valid = 1'b1;
            step();
            data_out_valid = 1'b0;
            if (i < 7) step();
        end
        for (int i = 0; i < 3; i++) begin
            chk("t2_resp_valid", resp_valid, 1'b1);
            chk("t2_resp_data", resp_data, blk);
            step();
        end
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;
        chk("t2_resp_done", resp_valid, 1'b0);
        chk("t2_req_ready", req_ready, 1'b1);

        // 3: command backpressure
        for (int i = 0; i < 8; i++) blk[i*64 +: 64] = 64'h00A0 + 64'(i);
        cmd_ready = 1'b0;
        issue(2'd0, 32'h55, blk);
        for (int i = 0; i < 5; i++) begin
            chk("t3_cmd_valid", cmd_valid, 1'b1);
            chk("t3_cmd", cmd, 2'd0);
            chk("t3_paddr", paddr, 32'h55);
            chk("t3_no_din", data_in_valid, 1'b0);
            chk("t3_req_ready", req_ready, 1'b0);
            step();
        end
        cmd_ready = 1'b1;
        step();

        // 4: data_in_ready toggling
        idx = 0;
        for (int c = 0; c < 40 && idx < 8; c++) begin
            data_in_ready = (c % 2 == 0);
            chk("t4_din_valid", data_in_valid, 1'b1);
            chk("t4_din", data_in, blk[idx*64 +: 64]);
            if (data_in_ready) idx++;
            step();
        end
        data_in_ready = 1'b1;
        chk("t4_beat_count", 512'(idx), 512'd8);
        chk("t4_din_valid_end", data_in_valid, 1'b0);
        chk("t4_req_ready", req_ready, 1'b1);

        // 5: reset in the middle of a read, then a clean read
        issue(2'd3, 32'h77, '0);
        step();
        data_out_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            data_out = 64'hDEAD_0000 + 64'(i);
            step();
        end
        data_out = 64'hDEAD_0003;
        chk("t5_mid_ready", data_out_ready, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_cmd_valid", cmd_valid, 1'b0);
        chk("t5_rst_din_valid", data_in_valid, 1'b0);
        chk("t5_rst_dout_ready", data_out_ready, 1'b0);
        chk("t5_rst_resp_valid", resp_valid, 1'b0);
        chk("t5_rst_resp_data", resp_data, '0);
        data_out_valid = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        for (int i = 0; i < 8; i++) blk[i*64 +: 64] = 64'h00B0 + 64'(i);
        issue(2'd2, 32'h99, '0);
        step();
        for (int i = 0; i < 8; i++) begin
            data_out       = blk[i*64 +: 64];
            data_out_valid = 1'b1;
            step();
        end
        data_out_valid = 1'b0;
        chk("t5_resp_valid", resp_valid, 1'b1);
        chk("t5_resp_data", resp_data, blk);
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;

        // 6: stray read beats in idle and during a write
        snap           = resp_data;
        data_out       = '1;
        data_out_valid = 1'b1;
        chk("t6_idle_dout_ready", data_out_ready, 1'b0);
        step();
        chk("t6_idle_resp_data", resp_data, snap);
        chk("t6_idle_req_ready", req_ready, 1'b1);
        for (int i = 0; i < 8; i++) blk[i*64 +: 64] = 64'h00C0 + 64'(i);
        issue(2'd0, 32'h2, blk);
        chk("t6_cmd_dout_ready", data_out_ready, 1'b0);
        step();
        for (int i = 0; i < 8; i++) begin
            chk("t6_w_dout_ready", data_out_ready, 1'b0);
            chk("t6_w_din", data_in, blk[i*64 +: 64]);
            chk("t6_w_block", resp_data, blk);
            step();
        end
        data_out_valid = 1'b0;
        chk("t6_req_ready", req_ready, 1'b1);
        chk("t6_resp_valid", resp_valid, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
